serial_result_pooler: RTL

- Downstream stage of top_serial_mode. It consumes each 8-bit convolution result (out) when is_done_o rises.
- Applies optional ReLU, then max-pools every POOL_N consecutive results.
- Stores pooled values in an internal buffer that a later stage or the host reads back.
- Raises frame-complete and overflow status flags.

---
 rtl/serial_result_pooler.sv | 128 ++++++++++++
 1 files changed

// File: rtl/serial_result_pooler.sv
// Pools serial convolution results: optional ReLU, signed max over POOL_N
// captures, and a pooled-result buffer with a registered read port.
module serial_result_pooler #(
  parameter int DATA_W    = 8,
  parameter int POOL_N    = 4,
  parameter int OUT_DEPTH = 16,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              conv_done_i,
  input  logic [DATA_W-1:0] conv_data_i,
  input  logic              relu_en_i,
  input  logic              clear_i,
  output logic              pool_valid_o,
  output logic [DATA_W-1:0] pool_data_o,
  output logic [ADDR_W-1:0] pool_addr_o,
  output logic              frame_done_o,
  output logic              overflow_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int CNT_W = $clog2(POOL_N);

  typedef enum logic {
    COLLECT,
    FULL
  } state_t;

  state_t state_q, state_d;

  logic                     done_q;
  logic [CNT_W-1:0]         grp_cnt;
  logic [ADDR_W-1:0]        wr_ptr;
  logic signed [DATA_W-1:0] run_max;
  logic signed [DATA_W-1:0] relu_v;
  logic signed [DATA_W-1:0] group_max;
  logic                     capture;
  logic                     accept;
  logic                     last_in_group;
  logic                     last_slot;
  logic                     write_en;
  logic [DATA_W-1:0]        mem [OUT_DEPTH];

  // Rising-edge detect on conv_done_i so a held level is taken only once;
  // the first element of a group seeds the running max, ties keep the old max.
  always_comb begin
    capture       = conv_done_i && !done_q;
    relu_v        = (relu_en_i && conv_data_i[DATA_W-1]) ? '0 : $signed(conv_data_i);
    group_max     = run_max;
    if (grp_cnt == '0) begin
      group_max = relu_v;
    end else if (relu_v > run_max) begin
      group_max = relu_v;
    end
    accept        = capture && !clear_i && (state_q == COLLECT);
    last_in_group = (grp_cnt == CNT_W'(POOL_N - 1));
    last_slot     = (wr_ptr == ADDR_W'(OUT_DEPTH - 1));
    write_en      = accept && last_in_group;
    state_d       = state_q;
    if (clear_i) begin
      state_d = COLLECT;
    end else if (write_en && last_slot) begin
      state_d = FULL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and status flags; clear wins over a coincident capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q       <= 1'b0;
      grp_cnt      <= '0;
      wr_ptr       <= '0;
      run_max      <= '0;
      pool_valid_o <= 1'b0;
      pool_data_o  <= '0;
      pool_addr_o  <= '0;
      frame_done_o <= 1'b0;
      overflow_o   <= 1'b0;
      rd_data_o    <= '0;
    end else begin
      done_q       <= conv_done_i;
      pool_valid_o <= write_en;
      rd_data_o    <= mem[rd_addr_i];
      if (clear_i) begin
        grp_cnt      <= '0;
        wr_ptr       <= '0;
        frame_done_o <= 1'b0;
        overflow_o   <= 1'b0;
      end else begin
        if (accept) begin
          run_max <= group_max;
          if (last_in_group) begin
            grp_cnt     <= '0;
            pool_data_o <= group_max;
            pool_addr_o <= wr_ptr;
            wr_ptr      <= wr_ptr + ADDR_W'(1);
            if (last_slot) begin
              frame_done_o <= 1'b1;
            end
          end else begin
            grp_cnt <= grp_cnt + CNT_W'(1);
          end
        end
        if (capture && (state_q == FULL)) begin
          overflow_o <= 1'b1;
        end
      end
    end
  end

  // Buffer storage carries no reset; reads see the pre-write value.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[wr_ptr] <= group_max;
    end
  end

endmodule
